// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle MIPS datapath: opcode decode, per-cycle strobes, retire counter.
// Strobes are a Moore decode of the state; FETCH, MEMRD and MEMWR hold until mem_ready.
module multicycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [3:0]         state,
    output logic               retire,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    state_t cur_state;
    state_t nxt_state;
    state_t out_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= S_FETCH;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire) begin
                instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      nxt_state = S_EXEC;
                    OP_LW, OP_SW:  nxt_state = S_MEMADR;
                    OP_BEQ:        nxt_state = S_BRANCH;
                    OP_J:          nxt_state = S_JUMP;
                    OP_ADDI:       nxt_state = S_ADDIEX;
                    default:       nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    nxt_state = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    nxt_state = S_MEMWR;
                end
            end
            S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt_state = S_RCOMP;
            S_ADDIEX: nxt_state = S_ADDIWB;
            default:  nxt_state = S_FETCH;
        endcase
    end

    // Outputs decode from FETCH while rst is high so reset looks like a stalled fetch.
    assign out_state = rst ? S_FETCH : cur_state;
    assign state     = out_state;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (out_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                illegal = (nxt_state == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RCOMP: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, randomized run against a path model, counter wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic [3:0]  state;
    logic        retire, illegal;
    logic [31:0] instr_count;

    logic        rst_w = 1'b1;
    logic [5:0]  opcode_w = 6'd2;
    logic        mem_ready_w = 1'b1;
    logic        w_pcw, w_pcwc, w_iord, w_mrd, w_mwr, w_irw, w_m2r, w_asa, w_rw, w_rd;
    logic [1:0]  w_pcs, w_asb, w_aop;
    logic [3:0]  w_state;
    logic        w_retire, w_illegal;
    logic [3:0]  w_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .retire(retire), .illegal(illegal),
        .instr_count(instr_count)
    );

    multicycle_control #(.COUNT_W(4)) dut_w (
        .clk(clk), .rst(rst_w), .opcode(opcode_w), .mem_ready(mem_ready_w),
        .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .IorD(w_iord), .MemRead(w_mrd),
        .MemWrite(w_mwr), .IRWrite(w_irw), .MemtoReg(w_m2r), .ALUSrcA(w_asa),
        .RegWrite(w_rw), .RegDst(w_rd), .PCSource(w_pcs), .ALUSrcB(w_asb),
        .ALUOp(w_aop), .state(w_state), .retire(w_retire), .illegal(w_illegal),
        .instr_count(w_count)
    );

    logic [15:0] dut_ctrl;
    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

    // Strobe table per state, straight from the datapath control description.
    function automatic logic [15:0] ctrl_exp(input int s, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd} = '0;
        pcs = 2'd0; asb = 2'd0; aop = 2'd0;
        case (s)
            0:  begin mrd = 1'b1; asb = 2'd1; pcw = mr; irw = mr; end
            1:  asb = 2'd3;
            2, 10: begin asa = 1'b1; asb = 2'd2; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'd2; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'd1; pcwc = 1'b1; pcs = 2'd1; end
            9:  begin pcw = 1'b1; pcs = 2'd2; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, asb, aop};
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input int st, input logic mr, input logic ret,
                           input logic ill, input logic [31:0] cnt);
        chk("state", idx, 64'(state), 64'(st));
        chk("strobes", idx, 64'(dut_ctrl), 64'(ctrl_exp(st, mr)));
        chk("retire", idx, 64'(retire), 64'(ret));
        chk("illegal", idx, 64'(illegal), 64'(ill));
        chk("instr_count", idx, 64'(instr_count), 64'(cnt));
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       mr;
        int         st;
        logic       ret;
        logic       ill;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input int op, input logic mr, input int st,
                       input logic ret, input logic ill, input int cnt);
        vec_t v;
        v.rst = r; v.op = 6'(op); v.mr = mr; v.st = st; v.ret = ret; v.ill = ill; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // Remaining states an opcode walks through after DECODE; empty means unsupported.
    function automatic void path_for(input logic [5:0] op, output int p[$]);
        p = {};
        case (op)
            6'd0:  p = {6, 7};
            6'd35: p = {2, 3, 4};
            6'd43: p = {2, 5};
            6'd4:  p = {8};
            6'd2:  p = {9};
            6'd8:  p = {10, 11};
            default: p = {};
        endcase
    endfunction

    initial begin
        int          m_st;
        logic [31:0] m_cnt;
        int          path[$];
        logic        e_ret, e_ill;

        // R-type
        add(1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 6, 0, 0, 0);
        add(0, 0, 1, 7, 1, 0, 0);
        // lw with a two-cycle memory stall
        add(0, 35, 1, 0, 0, 0, 1);
        add(0, 35, 1, 1, 0, 0, 1);
        add(0, 35, 1, 2, 0, 0, 1);
        add(0, 35, 0, 3, 0, 0, 1);
        add(0, 35, 0, 3, 0, 0, 1);
        add(0, 35, 1, 3, 0, 0, 1);
        add(0, 35, 1, 4, 1, 0, 1);
        // beq then j
        add(0, 4, 1, 0, 0, 0, 2);
        add(0, 4, 1, 1, 0, 0, 2);
        add(0, 4, 1, 8, 1, 0, 2);
        add(0, 2, 1, 0, 0, 0, 3);
        add(0, 2, 1, 1, 0, 0, 3);
        add(0, 2, 1, 9, 1, 0, 3);
        // unsupported opcode
        add(0, 63, 1, 0, 0, 0, 4);
        add(0, 63, 1, 1, 0, 1, 4);
        // sw interrupted by reset while the write is stalled
        add(0, 43, 1, 0, 0, 0, 4);
        add(0, 43, 1, 1, 0, 0, 4);
        add(0, 43, 1, 2, 0, 0, 4);
        add(0, 43, 0, 5, 0, 0, 4);
        add(1, 43, 0, 0, 0, 0, 4);
        add(0, 43, 0, 0, 0, 0, 0);
        add(0, 43, 1, 0, 0, 0, 0);
        add(0, 43, 1, 1, 0, 0, 0);
        add(0, 43, 1, 2, 0, 0, 0);
        add(0, 43, 1, 5, 1, 0, 0);
        // addi
        add(0, 8, 1, 0, 0, 0, 1);
        add(0, 8, 1, 1, 0, 0, 1);
        add(0, 8, 1, 10, 0, 0, 1);
        add(0, 8, 1, 11, 1, 0, 1);
        add(1, 0, 1, 0, 0, 0, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].mr;
            #1;
            chk_all(i, tbl[i].st, tbl[i].mr, tbl[i].ret, tbl[i].ill, 32'(tbl[i].cnt));
        end

        // Randomized run; the last table row reset the DUT.
        m_st = 0;
        m_cnt = 32'd0;
        path = {};
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_st == 0) begin
                case ($urandom_range(0, 7))
                    0: opcode = 6'd0;
                    1: opcode = 6'd35;
                    2: opcode = 6'd43;
                    3: opcode = 6'd4;
                    4: opcode = 6'd2;
                    5: opcode = 6'd8;
                    6: opcode = 6'd63;
                    default: opcode = 6'($urandom_range(0, 63));
                endcase
            end
            #1;
            if (rst) begin
                chk_all(1000 + i, 0, mem_ready, 1'b0, 1'b0, m_cnt);
                m_st = 0;
                m_cnt = 32'd0;
                path = {};
            end else begin
                e_ret = (m_st inside {4, 7, 8, 9, 11}) || (m_st == 5 && mem_ready);
                e_ill = 1'b0;
                if (m_st == 1) begin
                    path_for(opcode, path);
                    e_ill = (path.size() == 0);
                end
                chk_all(1000 + i, m_st, mem_ready, e_ret, e_ill, m_cnt);
                if (e_ret) m_cnt = m_cnt + 32'd1;
                if (m_st == 0) begin
                    m_st = mem_ready ? 1 : 0;
                end else if ((m_st == 3 || m_st == 5) && !mem_ready) begin
                    m_st = m_st;
                end else if (path.size() != 0) begin
                    m_st = path.pop_front();
                end else begin
                    m_st = 0;
                end
            end
        end

        // 17 back-to-back jumps on a 4-bit counter: one retire every three cycles.
        @(negedge clk);
        rst_w = 1'b0;
        for (int k = 0; k <= 51; k++) begin
            #1;
            chk("wrap_count", k, 64'(w_count), 64'((k / 3) % 16));
            @(negedge clk);
        end
        chk("wrap_final", 52, 64'(w_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode and drives the per-cycle control strobes for PC, memory, IR, register file and ALU operand muxes. It also produces the 2-bit `ALUOp` consumed by the ALU control decoder (00 add, 01 sub, 10 funct). It stalls on a memory-ready handshake and counts retired instructions.

## Interface
Parameters:
- `COUNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `opcode`  input  6  `IR[31:26]`, valid from DECODE onward.
- `mem_ready`  input  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  output  1 each  datapath strobes.
- `PCSource`  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUSrcB`  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `ALUOp`  output  2  to the ALU control decoder.
- `state`  output  4  current state encoding (debug).
- `retire`  output  1  one-cycle pulse on the final cycle of an instruction.
- `illegal`  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `instr_count`  output  COUNT_W  retired instructions since reset.

## Operation
State encoding: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RCOMP, 8 BRANCH, 9 JUMP, 10 ADDIEX, 11 ADDIWB. Codes 12–15 are unused and go to FETCH on the next edge.

Outputs are a Moore decode of `state`, except for the `mem_ready` gating noted in FETCH. Every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. PCWrite and IRWrite both equal `mem_ready`.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: MemRead=1, IorD=1.
- MEMWR: MemWrite=1, IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RCOMP: RegDst=1, RegWrite=1, MemtoReg=0.
- ADDIWB: RegDst=0, RegWrite=1, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.

Transitions:
- FETCH → DECODE when `mem_ready`=1; otherwise stay in FETCH.
- DECODE on opcode:
  - 0 → EXEC.
  - 35 (lw) or 43 (sw) → MEMADR.
  - 4 (beq) → BRANCH.
  - 2 (j) → JUMP.
  - 8 (addi) → ADDIEX.
  - anything else → FETCH, with `illegal`=1 during the DECODE cycle.
- MEMADR → MEMRD for opcode 35, MEMWR for opcode 43.
- MEMRD → MEMWB when `mem_ready`; otherwise hold.
- MEMWR → FETCH when `mem_ready`; otherwise hold. MemRead/MemWrite stay asserted while holding.
- EXEC → RCOMP; ADDIEX → ADDIWB.
- MEMWB, RCOMP, ADDIWB, BRANCH, JUMP → FETCH.

Retire and counter:
- `retire`=1 in MEMWB, RCOMP, ADDIWB, BRANCH and JUMP, and in MEMWR when `mem_ready`=1.
- It is 0 for illegal opcodes.
- `instr_count` increments on each cycle where `retire`=1 and wraps modulo 2^COUNT_W.

## Timing
- Reset: `rst`=1 at an edge forces `state`=FETCH and `instr_count`=0. This overrides any transition, including mid-instruction and mid-stall.
- While in reset: `MemRead`=1, `ALUSrcB`=01, `PCWrite`=`IRWrite`=`mem_ready`. All other outputs, `retire` and `illegal` are 0.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - R-type, sw, addi: 4 cycles.
  - beq, j: 3 cycles.
  - illegal opcode: 2 cycles.
- Each `mem_ready`=0 cycle spent in FETCH, MEMRD or MEMWR adds one cycle.
- `opcode` is sampled only in DECODE and MEMADR. It must be stable from the cycle after IRWrite until retire.

## Test plan
- Reset, then `mem_ready`=1 with an R-type (opcode 0): states 0,1,6,7,0. `ALUOp`=10 in EXEC; RegDst=RegWrite=1 in RCOMP; `instr_count` 0→1.
- lw (35) with `mem_ready` low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. MemRead=IorD=1 throughout MEMRD; `retire` asserts only in MEMWB.
- beq (4) then j (2): BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01. JUMP shows PCWrite=1, PCSource=10. `instr_count`=2 afterwards.
- Opcode 63: `illegal` pulses once in DECODE, next state is FETCH, `instr_count` unchanged.
- `rst` asserted in MEMWR while `mem_ready`=0: next cycle `state`=0, `instr_count`=0, MemWrite=0.
- COUNT_W=4, 17 back-to-back j instructions: `instr_count` wraps 15→0 and ends at 1.
